// File: rtl/uart_receiver.sv
// uart_receiver: start + 8 data (LSB first) + parity + stop receiver.
// The serial line is resynchronised, every bit is sampled at its middle,
// a low stop bit parks the receiver in BREAK until the line returns high,
// and error-free bytes are kept in a four-deep history (RXBUF[0] newest).
//
// Output handshake: rx_valid is a one-cycle strobe with no ready/back-pressure.
// rx_data, parity_error and framing_error change only in the rx_valid cycle
// and hold until the next frame completes; a slow consumer simply loses bytes.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic        PARITY       = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RX,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  output logic            parity_error,
  output logic            framing_error,
  output logic            busy,
  output logic [7:0]      most_recent_received,
  output logic [3:0][7:0] RXBUF,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // Last counter value of the half bit (start check) and of a full bit.
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  logic            sync1_q, rx_s_q;
  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bad_q, par_bad_d;
  logic            frame_done;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q, parity_error_q, framing_error_q;
  logic [3:0][7:0] rxbuf_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RX;
      rx_s_q  <= sync1_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, bit timing and data capture decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) state_d = S_PARITY;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bad_d = ((^shift_q) ^ rx_s_q) != PARITY;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          frame_done = 1'b1;
          state_d    = rx_s_q ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit counter, bit index, shift register and latched parity result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  // Frame results and history, updated on the stop-bit sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q      <= 1'b0;
      rx_data_q       <= '0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      rxbuf_q         <= '0;
    end else begin
      rx_valid_q <= frame_done;
      if (frame_done) begin
        rx_data_q       <= shift_q;
        parity_error_q  <= par_bad_q;
        framing_error_q <= ~rx_s_q;
        if (!par_bad_q && rx_s_q) rxbuf_q <= {rxbuf_q[2:0], shift_q};
      end
    end
  end

  // Output decode.
  always_comb begin
    busy                 = (state_q != S_IDLE);
    dbg_state_o          = state_q;
    rx_valid             = rx_valid_q;
    rx_data              = rx_data_q;
    parity_error         = parity_error_q;
    framing_error        = framing_error_q;
    RXBUF                = rxbuf_q;
    most_recent_received = rxbuf_q[0];
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames plus randomised traffic against a
// frame-level reference model (expected queue + byte history).
module tb_uart_receiver;

  localparam int   CPB = 16;
  localparam logic PAR = 1'b1;
  // Drive-to-strobe delay: two synchroniser flops, then the strobe appears
  // CPB/2 + 10*CPB + 1 cycles after the cycle that first sees rx_s low.
  localparam int   LAT = 2 + (CPB / 2 + 10 * CPB + 1);

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            RX  = 1'b1;
  logic [7:0]      rx_data;
  logic            rx_valid, parity_error, framing_error, busy;
  logic [7:0]      most_recent_received;
  logic [3:0][7:0] RXBUF;
  logic [2:0]      dbg_state_o;

  uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY(PAR)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .RX                   (RX),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .parity_error         (parity_error),
    .framing_error        (framing_error),
    .busy                 (busy),
    .most_recent_received (most_recent_received),
    .RXBUF                (RXBUF),
    .dbg_state_o          (dbg_state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q entry = {framing_error, parity_error, data}
  logic [9:0] exp_q[$];
  int         t_q[$];
  logic [7:0] hist[$] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] m_data = 8'h00;
  logic       m_par  = 1'b0;
  logic       m_frm  = 1'b0;
  logic       prev_valid = 1'b0;

  function automatic logic [7:0] hist_at(input int i);
    return hist[hist.size() - 1 - i];
  endfunction

  // Parity bit that makes the total number of ones match PAR.
  function automatic logic good_pbit(input logic [7:0] d);
    return 1'(($countones(d) + int'(PAR)) % 2);
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; leaves RX at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stopb,
                            input int stop_len);
    logic [10:0] bits;
    logic        perr;
    bits = {stopb, pbit, data, 1'b0};
    perr = (($countones({pbit, data}) % 2) != int'(PAR));
    exp_q.push_back({~stopb, perr, data});
    t_q.push_back(cyc);
    for (int b = 0; b < 11; b++) begin
      RX = bits[b];
      repeat ((b == 10) ? stop_len : CPB) @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [9:0] e;
    int         t0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hist   = '{8'h00, 8'h00, 8'h00, 8'h00};
        m_data = 8'h00;
        m_par  = 1'b0;
        m_frm  = 1'b0;
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_rx_valid", rx_valid, 1'b0);
        check_eq("rst_par_err", parity_error, 1'b0);
        check_eq("rst_frm_err", framing_error, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rxbuf", RXBUF, 32'h0);
      end else begin
        if (prev_valid) check_eq("valid_width", rx_valid, 1'b0);
        if (rx_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_valid", rx_valid, 1'b0);
          end else begin
            e  = exp_q.pop_front();
            t0 = t_q.pop_front();
            check_eq("latency", cyc - t0, LAT);
            check_eq("rx_data", rx_data, e[7:0]);
            check_eq("par_err", parity_error, e[8]);
            check_eq("frm_err", framing_error, e[9]);
            m_data = e[7:0];
            m_par  = e[8];
            m_frm  = e[9];
            if (!e[8] && !e[9]) hist.push_back(e[7:0]);
          end
        end else begin
          check_eq("hold_data", rx_data, m_data);
          check_eq("hold_par", parity_error, m_par);
          check_eq("hold_frm", framing_error, m_frm);
        end
        for (int i = 0; i < 4; i++) check_eq($sformatf("rxbuf%0d", i), RXBUF[i], hist_at(i));
        check_eq("most_recent", most_recent_received, hist_at(0));
      end
      prev_valid = rx_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    logic       seen;
    logic [7:0] d;
    logic       pb, sb;

    rst = 1'b1;
    RX  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean frame, correct parity.
    send_frame(8'hA5, 1'b1, 1'b1, CPB);
    drain();
    check_eq("a5_buf0", RXBUF[0], 8'hA5);
    check_eq("a5_par", parity_error, 1'b0);

    // Same byte, wrong parity: reported, history untouched.
    send_frame(8'hA5, 1'b0, 1'b1, CPB);
    drain();
    check_eq("a5bad_par", parity_error, 1'b1);
    check_eq("a5bad_buf1", RXBUF[1], 8'h00);

    // Low stop bit with the line held low 40 cycles: BREAK until release.
    send_frame(8'h3C, good_pbit(8'h3C), 1'b0, CPB);
    repeat (24) begin
      check_eq("break_busy", busy, 1'b1);
      @(negedge clk);
    end
    check_eq("break_frm", framing_error, 1'b1);
    RX = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("break_exit_busy", busy, 1'b0);
    check_eq("break_buf0", RXBUF[0], 8'hA5);

    // Start glitch shorter than half a bit.
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX   = 1'b1;
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check_eq("glitch_busy_seen", seen, 1'b1);
    check_eq("glitch_idle", busy, 1'b0);
    check_eq("glitch_data", rx_data, 8'h3C);

    // Back-to-back frames with no idle time.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), good_pbit(8'(i)), 1'b1, CPB);
    drain();
    check_eq("b2b_buf0", RXBUF[0], 8'h05);
    check_eq("b2b_buf1", RXBUF[1], 8'h04);
    check_eq("b2b_buf2", RXBUF[2], 8'h03);
    check_eq("b2b_buf3", RXBUF[3], 8'h02);

    // Reset in the middle of data bit 3, then a normal frame.
    v  = 8'h5A;
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      RX = v[b];
      repeat (CPB) @(negedge clk);
    end
    RX = v[3];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    RX  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_data", rx_data, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'h3C, good_pbit(8'h3C), 1'b1, CPB);
    drain();
    check_eq("postrst_buf0", RXBUF[0], 8'h3C);
    check_eq("postrst_buf1", RXBUF[1], 8'h00);
    check_eq("postrst_par", parity_error, 1'b0);

    // Randomised traffic: random bytes, occasional parity/stop faults.
    for (int i = 0; i < 40; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = good_pbit(d);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      sb = ($urandom_range(0, 5) != 0);
      send_frame(d, pb, sb, CPB);
      if (!sb) begin
        RX = 1'b1;
        repeat ($urandom_range(2, CPB)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();
    repeat (CPB) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range even values 4..65534.
REQ-002 Parameter PARITY, default 1'b1, parity sense: 0 = even, 1 = odd.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 RX  input  1  serial line, idle high, asynchronous to clk.
REQ-006 rx_data  output  8  last received byte, held until next frame completes.
REQ-007 rx_valid  output  1  one-cycle pulse, frame complete.
REQ-008 parity_error  output  1  parity check failed for the frame flagged by rx_valid.
REQ-009 framing_error  output  1  stop bit sampled low for the frame flagged by rx_valid.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 most_recent_received  output  8  equals RXBUF[0].
REQ-012 RXBUF  output  8 x [3:0]  four-entry history of error-free bytes; index 0 newest.

Function
REQ-013 Frame format: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
REQ-014 RX passes through a two-flop synchronizer (rx_s); both flops reset to 1; all decisions use rx_s only.
REQ-015 States: IDLE, START, DATA, PARITY, STOP, BREAK; one bit counter (0..CLKS_PER_BIT-1), one bit index (0..7).
REQ-016 IDLE: on rx_s==0 -> START, counter=0; this is cycle T0.
REQ-017 START: counter increments; at counter==CLKS_PER_BIT/2-1, rx_s==0 -> DATA with counter=0 and index=0; rx_s==1 -> IDLE (glitch, no outputs change).
REQ-018 DATA/PARITY/STOP: counter increments; sample rx_s at counter==CLKS_PER_BIT-1, then counter=0.
REQ-019 Sample points: start at T0+CLKS_PER_BIT/2, data bit k at T0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT, parity at +9*CLKS_PER_BIT, stop at +10*CLKS_PER_BIT.
REQ-020 DATA: sample stored into shift-register bit [index]; after index 7 -> PARITY, else index+1.
REQ-021 Parity check: XOR of 8 data bits and parity bit SHALL equal PARITY; mismatch sets parity_error.
REQ-022 STOP sample: rx_s==1 -> IDLE; rx_s==0 -> framing_error and -> BREAK.
REQ-023 BREAK: remain until rx_s==1, then -> IDLE; no start detection while in BREAK.
REQ-024 Cycle after stop sample: rx_valid=1 for exactly one cycle; rx_data, parity_error, framing_error updated in the same cycle and held until the next frame's rx_valid.
REQ-025 RXBUF shifts (RXBUF[3]<=RXBUF[2] ... RXBUF[0]<=rx byte) in the rx_valid cycle only when parity_error==0 and framing_error==0; oldest entry discarded.
REQ-026 A start edge arriving the cycle after a good stop sample SHALL be detected (back-to-back frames with no idle time).
REQ-027 No overrun handling: rx_data overwritten by each completed frame regardless of consumer.

Reset
REQ-028 During rst: state IDLE, counter and index 0, synchronizer flops 1, rx_data 0, rx_valid 0, parity_error 0, framing_error 0, busy 0, all RXBUF entries 0.
REQ-029 rst asserted mid-frame aborts the frame immediately; no rx_valid for the aborted frame.
REQ-030 After rst deassertion, first start detection requires rx_s to be 0 (line low for at least two clk after synchronizer).

Verification
REQ-031 0xA5 (parity bit 1, CLKS_PER_BIT=16) -> rx_valid one cycle at T0+169, rx_data=0xA5, both errors 0, RXBUF[0]=0xA5.
REQ-032 0xA5 with parity bit 0 -> rx_valid, parity_error=1, rx_data=0xA5, RXBUF unchanged.
REQ-033 0x3C with stop bit 0, RX held low 40 cycles -> framing_error=1, busy stays 1 until RX high, no second frame detected.
REQ-034 RX low for 4 cycles then high -> busy pulses, returns to IDLE, no rx_valid, outputs unchanged.
REQ-035 Back-to-back frames 0x01..0x05 -> five rx_valid pulses; RXBUF[0..3]=0x05,0x04,0x03,0x02.
REQ-036 rst asserted during data bit 3, then frame 0x3C -> all outputs reset values, no rx_valid for aborted frame, 0x3C then received with errors 0.
